receptor_serie: RTL and testbench

Serial-to-parallel receiver, the companion of the 4-bit shift register. It reconstructs a WIDTH-bit word from the register's S_OUT stream and presents it with a VALID/ACK handshake. It sits on the downstream end of the serial link. Framing is one low start bit followed by WIDTH data bits, plus an optional parity bit.

---
 rtl/receptor_pkg.sv | 20 ++
 rtl/receptor_serie_if.sv | 32 +++
 rtl/receptor_serie_contador_bits.sv | 27 ++
 rtl/receptor_serie.sv | 120 ++++++++++++
 tb/tb_receptor_serie.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/receptor_pkg.sv
// rtl/receptor_pkg.sv - shared constants and state encoding for receptor_serie (PARITY_EN adds the PAR state)
package receptor_pkg;

    localparam int   DEF_WIDTH = 4;
    localparam int   CNT_W     = $clog2(DEF_WIDTH);
    localparam logic START_BIT = 1'b0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
`ifdef PARITY_EN
        PAR  = 2'd2,
`endif
        RECV = 2'd1
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/receptor_serie_if.sv
// rtl/receptor_serie_if.sv - serial-line and word-handshake bundle for receptor_serie (PARITY_EN adds PAR_ERR)
interface receptor_serie_if #(parameter int WIDTH = 4);

    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic             ACK;
    logic [WIDTH-1:0] Q;
    logic             VALID;
    logic             BUSY;
    logic             OVR;
`ifdef PARITY_EN
    logic             PAR_ERR;
`endif

    modport master (
        output ENB, DIR, S_IN, ACK,
`ifdef PARITY_EN
        input  PAR_ERR,
`endif
        input  Q, VALID, BUSY, OVR
    );

    modport slave (
        input  ENB, DIR, S_IN, ACK,
`ifdef PARITY_EN
        output PAR_ERR,
`endif
        output Q, VALID, BUSY, OVR
    );

endinterface

// File: rtl/receptor_serie_contador_bits.sv
// rtl/receptor_serie_contador_bits.sv - enable-gated data-bit counter with terminal flag at WIDTH-1
module contador_bits #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic RST,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tc = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/receptor_serie.sv
// rtl/receptor_serie.sv - start-bit framed serial-to-parallel receiver with VALID/ACK handshake
// Build option: PARITY_EN appends an even-parity bit and drives PAR_ERR.
module receptor_serie
    import receptor_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             RST,
    receptor_serie_if.slave  bus
);

    localparam int LCNT_W = cnt_width(WIDTH);

    state_t           r_state, w_next;
    logic             w_start, w_shift, w_done, w_tc;
    logic             r_dir;
    logic [WIDTH-1:0] r_shift, w_shift_next, w_q_load;
    logic [WIDTH-1:0] r_q;
    logic             r_valid, r_ovr;
`ifdef PARITY_EN
    logic             r_par_err;
`endif

    contador_bits #(.WIDTH(WIDTH), .CNT_W(LCNT_W)) u_cnt (
        .clk   (clk),
        .RST   (RST),
        .i_en  (w_shift),
        .i_clr (w_start),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_shift = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ENB && bus.S_IN == START_BIT) begin
                    w_start = 1'b1;
                    w_next  = RECV;
                end
            end
            RECV: begin
                if (bus.ENB) begin
                    w_shift = 1'b1;
                    if (w_tc) begin
`ifdef PARITY_EN
                        w_next = PAR;
`else
                        w_done = 1'b1;
                        w_next = IDLE;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            PAR: begin
                if (bus.ENB) begin
                    w_done = 1'b1;
                    w_next = IDLE;
                end
            end
`endif
            default: w_next = IDLE;
        endcase
    end

    // Direction is latched at the start bit so a mid-frame DIR change cannot scramble the word.
    assign w_shift_next = r_dir ? {r_shift[WIDTH-2:0], bus.S_IN}
                                : {bus.S_IN, r_shift[WIDTH-1:1]};
`ifdef PARITY_EN
    assign w_q_load = r_shift;
`else
    assign w_q_load = w_shift_next;
`endif

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_dir     <= 1'b0;
            r_shift   <= '0;
            r_q       <= '0;
            r_valid   <= 1'b0;
            r_ovr     <= 1'b0;
`ifdef PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            if (w_start) r_dir   <= bus.DIR;
            if (w_shift) r_shift <= w_shift_next;
            if (w_done)  r_q     <= w_q_load;

            if (w_done)       r_valid <= 1'b1;
            else if (bus.ACK) r_valid <= 1'b0;

            // ACK on the completion cycle consumes the old word, so no overrun.
            if (bus.ACK)                r_ovr <= 1'b0;
            else if (w_done && r_valid) r_ovr <= 1'b1;
`ifdef PARITY_EN
            if (w_done)       r_par_err <= (^r_shift) ^ bus.S_IN;
            else if (bus.ACK) r_par_err <= 1'b0;
`endif
        end
    end

    assign bus.Q     = r_q;
    assign bus.VALID = r_valid;
    assign bus.OVR   = r_ovr;
    assign bus.BUSY  = (r_state != IDLE);
`ifdef PARITY_EN
    assign bus.PAR_ERR = r_par_err;
`endif

endmodule

// File: tb/tb_receptor_serie.sv
// tb/tb_receptor_serie.sv - directed self-checking bench for receptor_serie (PARITY_EN enables parity steps)
module tb_receptor_serie;
    import receptor_pkg::*;

    localparam int W = 4;

    logic clk;
    logic RST;
    int   vectors;
    int   miscompares;

    receptor_serie_if #(.WIDTH(W)) bus ();

    receptor_serie #(.WIDTH(W)) dut (
        .clk (clk),
        .RST (RST),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one ENB/S_IN pair, let one rising edge sample it, then settle.
    task automatic step(input logic s, input logic e);
        bus.S_IN = s;
        bus.ENB  = e;
        @(posedge clk);
        #1;
    endtask

    // Start bit plus W data bits in wire order; ACK optionally raised on the last edge.
    task automatic send(input logic [W-1:0] d, input logic ack_last);
        step(1'b0, 1'b1);
        for (int i = 0; i < W; i++) begin
            if (i == W - 1) bus.ACK = ack_last;
            step(bus.DIR ? d[W-1-i] : d[i], 1'b1);
        end
        bus.ACK = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.ACK = 1'b1;
        step(1'b1, 1'b1);
        bus.ACK = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST      = 1'b1;
        bus.ENB  = 1'b0;
        bus.DIR  = 1'b1;
        bus.S_IN = 1'b1;
        bus.ACK  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_q", bus.Q, 0);
        check("rst_valid", bus.VALID, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_ovr", bus.OVR, 0);
        RST = 1'b0;
        repeat (10) step(1'b1, 1'b1);
        check("idle_busy", bus.BUSY, 0);
        check("idle_valid", bus.VALID, 0);
        check("idle_q", bus.Q, 0);

        // MSB first, 0001
        bus.DIR = 1'b1;
        step(1'b0, 1'b1);
        check("msb_busy_after_start", bus.BUSY, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("msb_not_yet_valid", bus.VALID, 0);
        step(1'b1, 1'b1);
        check("msb_q", bus.Q, 4'b0001);
        check("msb_valid", bus.VALID, 1);
        check("msb_busy_done", bus.BUSY, 0);
        ack_pulse();
        check("msb_ack_valid", bus.VALID, 0);
        check("msb_ack_q_hold", bus.Q, 4'b0001);
        ack_pulse();
        check("ack_idle_noeffect", bus.VALID, 0);

        // LSB first with a 2-cycle stall between data bits 2 and 3 (wire bits 0,0,0,1)
        bus.DIR = 1'b0;
        step(1'b0, 1'b1);
        bus.DIR = 1'b1;
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("stall_busy", bus.BUSY, 1);
        step(1'b0, 1'b1);
        check("stall_not_valid", bus.VALID, 0);
        step(1'b1, 1'b1);
        check("lsb_q", bus.Q, 4'b1000);
        check("lsb_valid", bus.VALID, 1);
        ack_pulse();

        // Overrun: two frames, no ACK
        bus.DIR = 1'b1;
        send(4'b1010, 1'b0);
        check("ovr_first_q", bus.Q, 4'b1010);
        check("ovr_first_ovr", bus.OVR, 0);
        send(4'b0110, 1'b0);
        check("ovr_q", bus.Q, 4'b0110);
        check("ovr_valid", bus.VALID, 1);
        check("ovr_flag", bus.OVR, 1);
        ack_pulse();
        check("ovr_ack_clear", bus.OVR, 0);
        check("ovr_ack_valid", bus.VALID, 0);

        // Completion coincident with ACK
        send(4'b1010, 1'b0);
        send(4'b0110, 1'b1);
        check("simul_q", bus.Q, 4'b0110);
        check("simul_valid", bus.VALID, 1);
        check("simul_ovr", bus.OVR, 0);

        // Reset mid-frame, with an unacknowledged word still pending
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        RST = 1'b1;
        #1;
        check("midrst_busy", bus.BUSY, 0);
        check("midrst_valid", bus.VALID, 0);
        check("midrst_q", bus.Q, 0);
        @(posedge clk);
        #1;
        RST = 1'b0;
        bus.DIR = 1'b1;
        send(4'b1111, 1'b0);
        check("post_rst_q", bus.Q, 4'b1111);
        check("post_rst_valid", bus.VALID, 1);
        check("post_rst_ovr", bus.OVR, 0);
        ack_pulse();

`ifdef PARITY_EN
        // 0111 has odd weight; parity bit 1 makes it even
        send(4'b0111, 1'b0);
        check("par_wait_valid", bus.VALID, 0);
        check("par_wait_busy", bus.BUSY, 1);
        step(1'b1, 1'b1);
        check("par_ok_valid", bus.VALID, 1);
        check("par_ok_q", bus.Q, 4'b0111);
        check("par_ok_err", bus.PAR_ERR, 0);
        ack_pulse();
        send(4'b0111, 1'b0);
        step(1'b0, 1'b1);
        check("par_bad_err", bus.PAR_ERR, 1);
        check("par_bad_valid", bus.VALID, 1);
        ack_pulse();
        check("par_ack_err", bus.PAR_ERR, 0);
        check("par_ack_valid", bus.VALID, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
